// File: rtl/udp_pkg.sv
// Shared definitions for the GMII UDP receive path: FSM state encodings and
// protocol constants for Ethernet / IPv4 / UDP framing.
package udp_pkg;

    // One-hot receive FSM states.
    typedef enum logic [6:0] {
        st_idle     = 7'b000_0001,
        st_preamble = 7'b000_0010,
        st_eth_head = 7'b000_0100,
        st_ip_head  = 7'b000_1000,
        st_udp_head = 7'b001_0000,
        st_rx_data  = 7'b010_0000,
        st_rx_end   = 7'b100_0000
    } rx_state_t;

    localparam logic [15:0] ETH_TYPE_IPV4 = 16'h0800;
    localparam logic [7:0]  IP_PROTO_UDP  = 8'd17;
    localparam logic [7:0]  PREAMBLE_BYTE = 8'h55;
    localparam logic [7:0]  SFD_BYTE      = 8'hD5;
    localparam logic [47:0] BROADCAST_MAC = 48'hFF_FF_FF_FF_FF_FF;

    localparam int unsigned ETH_HEAD_LEN  = 14;
    localparam int unsigned UDP_HEAD_LEN  = 8;
    // 0x55 bytes expected after the one that triggers st_preamble.
    localparam int unsigned PREAMBLE_REST = 6;

endpackage

// File: rtl/ip_csum_acc.sv
// One's-complement accumulator over a byte stream taken as 16-bit big-endian
// words. sum_c is the folded sum including the word completed this cycle, so
// the caller can judge the header on its final byte.
// Ports: clk, rst_n; clr restarts the sum; byte_en/byte_odd/data feed bytes
// (even byte = high half); sum_c folded 16-bit result.
module ip_csum_acc (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        clr,
    input  logic        byte_en,
    input  logic        byte_odd,
    input  logic [7:0]  data,
    output logic [15:0] sum_c
);

    logic [7:0]  hi_byte;
    logic [31:0] acc;
    logic [31:0] acc_c;
    logic [16:0] fold1_c;

    // Include the word completing on this byte so the result is current.
    always_comb begin
        acc_c = acc;
        if (byte_en && byte_odd) begin
            acc_c = acc + 32'({hi_byte, data});
        end
        fold1_c = {1'b0, acc_c[15:0]} + {1'b0, acc_c[31:16]};
        sum_c   = fold1_c[15:0] + 16'(fold1_c[16]);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hi_byte <= 8'd0;
            acc     <= 32'd0;
        end else if (clr) begin
            hi_byte <= 8'd0;
            acc     <= 32'd0;
        end else if (byte_en) begin
            if (byte_odd) begin
                acc <= acc_c;
            end else begin
                hi_byte <= data;
            end
        end
    end

endmodule

// File: rtl/udp_rx.sv
// GMII receive-side UDP deframer. Strips preamble/SFD, Ethernet, IPv4 (with
// options) and UDP headers, filters on destination MAC/EtherType/protocol/IP
// and streams the UDP payload.
// Ports: clk, rst_n; gmii_rx_dv/gmii_rxd from the PHY; rec_en/rec_data payload
// byte stream; rec_pkt_done end pulse with rec_byte_num length; rx_err pulse on
// truncated/malformed frames; src_mac/src_ip of the last accepted packet.
// Optional: define UDP_RX_IP_CHECKSUM_EN to verify the IPv4 header checksum.
module udp_rx
    import udp_pkg::*;
#(
    parameter logic [47:0] BOARD_MAC = 48'h00_11_22_33_44_55,
    parameter logic [31:0] BOARD_IP  = {8'd192, 8'd168, 8'd1, 8'd123}
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        gmii_rx_dv,
    input  logic [7:0]  gmii_rxd,
    output logic        rec_en,
    output logic [7:0]  rec_data,
    output logic        rec_pkt_done,
    output logic [15:0] rec_byte_num,
    output logic        rx_err,
    output logic [47:0] src_mac,
    output logic [31:0] src_ip
);

    rx_state_t   state, next_state;
    logic        dv_d;
    logic [7:0]  rxd_d;
    logic        armed;
    logic [15:0] cnt, cnt_nxt;
    logic [47:0] dst_mac_r;
    logic [47:0] src_mac_tmp;
    logic [7:0]  type_hi;
    logic [15:0] ip_hlen;
    logic [31:0] src_ip_tmp;
    logic [23:0] dst_ip_r;
    logic [15:0] udp_len;
    logic        done_pend;
    logic        en_c, err_c, done_now_c, done_last_c;

`ifdef UDP_RX_IP_CHECKSUM_EN
    logic [15:0] csum_c;

    ip_csum_acc u_csum (
        .clk      (clk),
        .rst_n    (rst_n),
        .clr      (state == st_eth_head),
        .byte_en  ((state == st_ip_head) && dv_d),
        .byte_odd (cnt[0]),
        .data     (rxd_d),
        .sum_c    (csum_c)
    );
`endif

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= st_idle;
            cnt   <= 16'd0;
        end else begin
            state <= next_state;
            cnt   <= cnt_nxt;
        end
    end

    // Next-state and per-cycle strobes.
    always_comb begin
        next_state  = state;
        cnt_nxt     = cnt + 16'd1;
        en_c        = 1'b0;
        err_c       = 1'b0;
        done_now_c  = 1'b0;
        done_last_c = 1'b0;
        case (state)
            st_idle: begin
                cnt_nxt = 16'd0;
                if (armed && dv_d && rxd_d == PREAMBLE_BYTE) begin
                    next_state = st_preamble;
                end
            end
            st_preamble: begin
                if (!dv_d) begin
                    next_state = st_idle;
                    err_c      = 1'b1;
                    cnt_nxt    = 16'd0;
                end else if (cnt < 16'(PREAMBLE_REST)) begin
                    if (rxd_d != PREAMBLE_BYTE) begin
                        next_state = st_rx_end;
                        cnt_nxt    = 16'd0;
                    end
                end else begin
                    next_state = (rxd_d == SFD_BYTE) ? st_eth_head : st_rx_end;
                    cnt_nxt    = 16'd0;
                end
            end
            st_eth_head: begin
                if (!dv_d) begin
                    next_state = st_idle;
                    err_c      = 1'b1;
                    cnt_nxt    = 16'd0;
                end else if (cnt == 16'(ETH_HEAD_LEN - 1)) begin
                    cnt_nxt = 16'd0;
                    if ((dst_mac_r == BOARD_MAC || dst_mac_r == BROADCAST_MAC) &&
                        {type_hi, rxd_d} == ETH_TYPE_IPV4) begin
                        next_state = st_ip_head;
                    end else begin
                        next_state = st_rx_end;
                    end
                end
            end
            st_ip_head: begin
                if (!dv_d) begin
                    next_state = st_idle;
                    err_c      = 1'b1;
                    cnt_nxt    = 16'd0;
                end else if (cnt == 16'd0 && rxd_d[7:4] != 4'd4) begin
                    next_state = st_rx_end;
                    cnt_nxt    = 16'd0;
                end else if (cnt == 16'd0 && rxd_d[3:0] < 4'd5) begin
                    next_state = st_rx_end;
                    err_c      = 1'b1;
                    cnt_nxt    = 16'd0;
                end else if (cnt == 16'd9 && rxd_d != IP_PROTO_UDP) begin
                    next_state = st_rx_end;
                    cnt_nxt    = 16'd0;
                end else if (cnt == 16'd19 && {dst_ip_r, rxd_d} != BOARD_IP) begin
                    next_state = st_rx_end;
                    cnt_nxt    = 16'd0;
                end else if (cnt != 16'd0 && cnt == ip_hlen - 16'd1) begin
                    cnt_nxt    = 16'd0;
                    next_state = st_udp_head;
`ifdef UDP_RX_IP_CHECKSUM_EN
                    if (csum_c != 16'hFFFF) begin
                        next_state = st_rx_end;
                        err_c      = 1'b1;
                    end
`endif
                end
            end
            st_udp_head: begin
                if (!dv_d) begin
                    next_state = st_idle;
                    err_c      = 1'b1;
                    cnt_nxt    = 16'd0;
                end else if (cnt == 16'(UDP_HEAD_LEN - 1)) begin
                    cnt_nxt = 16'd0;
                    if (udp_len < 16'(UDP_HEAD_LEN)) begin
                        next_state = st_rx_end;
                        err_c      = 1'b1;
                    end else if (udp_len == 16'(UDP_HEAD_LEN)) begin
                        next_state = st_rx_end;
                        done_now_c = 1'b1;
                    end else begin
                        next_state = st_rx_data;
                    end
                end
            end
            st_rx_data: begin
                if (!dv_d) begin
                    next_state = st_idle;
                    err_c      = 1'b1;
                    cnt_nxt    = 16'd0;
                end else begin
                    en_c = 1'b1;
                    // Last payload byte; padding and FCS follow in st_rx_end.
                    if (cnt == udp_len - 16'(UDP_HEAD_LEN + 1)) begin
                        done_last_c = 1'b1;
                        next_state  = st_rx_end;
                        cnt_nxt     = 16'd0;
                    end
                end
            end
            st_rx_end: begin
                cnt_nxt = 16'd0;
                if (!dv_d) begin
                    next_state = st_idle;
                end
            end
            default: begin
                next_state = st_idle;
                cnt_nxt    = 16'd0;
            end
        endcase
    end

    // Input registers, header field capture and registered outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            dv_d         <= 1'b0;
            rxd_d        <= 8'd0;
            armed        <= 1'b0;
            dst_mac_r    <= 48'd0;
            src_mac_tmp  <= 48'd0;
            type_hi      <= 8'd0;
            ip_hlen      <= 16'd0;
            src_ip_tmp   <= 32'd0;
            dst_ip_r     <= 24'd0;
            udp_len      <= 16'd0;
            done_pend    <= 1'b0;
            rec_en       <= 1'b0;
            rec_data     <= 8'd0;
            rec_pkt_done <= 1'b0;
            rec_byte_num <= 16'd0;
            rx_err       <= 1'b0;
            src_mac      <= 48'd0;
            src_ip       <= 32'd0;
        end else begin
            dv_d  <= gmii_rx_dv;
            rxd_d <= gmii_rxd;
            // After reset, ignore the rest of any frame in flight until dv drops.
            if (!dv_d) begin
                armed <= 1'b1;
            end

            if (state == st_eth_head) begin
                if (cnt < 16'd6) begin
                    dst_mac_r <= {dst_mac_r[39:0], rxd_d};
                end else if (cnt < 16'd12) begin
                    src_mac_tmp <= {src_mac_tmp[39:0], rxd_d};
                end else if (cnt == 16'd12) begin
                    type_hi <= rxd_d;
                end
            end

            if (state == st_ip_head) begin
                if (cnt == 16'd0) begin
                    ip_hlen <= {10'd0, rxd_d[3:0], 2'b00};
                end else if (cnt >= 16'd12 && cnt <= 16'd15) begin
                    src_ip_tmp <= {src_ip_tmp[23:0], rxd_d};
                end else if (cnt >= 16'd16 && cnt <= 16'd18) begin
                    dst_ip_r <= {dst_ip_r[15:0], rxd_d};
                end
            end

            if (state == st_udp_head) begin
                if (cnt == 16'd4) begin
                    udp_len[15:8] <= rxd_d;
                end else if (cnt == 16'd5) begin
                    udp_len[7:0] <= rxd_d;
                end
            end

            rec_en <= en_c;
            if (en_c) begin
                rec_data <= rxd_d;
            end
            rx_err       <= err_c;
            done_pend    <= done_last_c;
            rec_pkt_done <= done_now_c | done_pend;
            if (done_now_c || done_last_c) begin
                rec_byte_num <= udp_len - 16'(UDP_HEAD_LEN);
                src_mac      <= src_mac_tmp;
                src_ip       <= src_ip_tmp;
            end
        end
    end

endmodule

// File: tb/tb_udp_rx.sv
// Directed self-checking bench for udp_rx: builds complete GMII frames and
// checks the emitted payload stream, completion pulse, length and errors.
module tb_udp_rx;

    localparam logic [47:0] BOARD_MAC = 48'h00_11_22_33_44_55;
    localparam logic [31:0] BOARD_IP  = {8'd192, 8'd168, 8'd1, 8'd123};
    localparam logic [47:0] SRC_MAC   = 48'h02_AA_BB_CC_DD_EE;
    localparam logic [31:0] SRC_IP    = {8'd192, 8'd168, 8'd1, 8'd10};
    localparam logic [47:0] BCAST     = 48'hFF_FF_FF_FF_FF_FF;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        gmii_rx_dv = 1'b0;
    logic [7:0]  gmii_rxd = 8'd0;
    logic        rec_en;
    logic [7:0]  rec_data;
    logic        rec_pkt_done;
    logic [15:0] rec_byte_num;
    logic        rx_err;
    logic [47:0] src_mac;
    logic [31:0] src_ip;

    int total = 0;
    int bad   = 0;

    logic [7:0] frm[$];
    logic [7:0] pl[$];
    logic [7:0] got[$];
    int n_done, n_err, cyc, last_en_cyc, done_cyc;
    logic [15:0] done_num;

    udp_rx #(.BOARD_MAC(BOARD_MAC), .BOARD_IP(BOARD_IP)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .gmii_rx_dv   (gmii_rx_dv),
        .gmii_rxd     (gmii_rxd),
        .rec_en       (rec_en),
        .rec_data     (rec_data),
        .rec_pkt_done (rec_pkt_done),
        .rec_byte_num (rec_byte_num),
        .rx_err       (rx_err),
        .src_mac      (src_mac),
        .src_ip       (src_ip)
    );

    always #4 clk = ~clk;

    always @(negedge clk) begin
        cyc <= cyc + 1;
        if (rst_n) begin
            if (rec_en) begin
                got.push_back(rec_data);
                last_en_cyc = cyc;
            end
            if (rec_pkt_done) begin
                n_done++;
                done_cyc = cyc;
                done_num = rec_byte_num;
            end
            if (rx_err) n_err++;
        end
    end

    task automatic clr_mon();
        got.delete();
        n_done = 0;
        n_err  = 0;
    endtask

    task automatic build_frame(input logic [47:0] dmac, input logic [15:0] etype,
                               input int ihl, input logic [7:0] proto,
                               input logic [31:0] dip, input logic bad_csum);
        logic [7:0]  hdr[$];
        logic [15:0] ulen;
        logic [15:0] tot;
        logic [31:0] s;
        logic [15:0] cs;
        int hlen;
        hlen = ihl * 4;
        ulen = 16'(pl.size() + 8);
        tot  = 16'(hlen) + ulen;
        hdr.push_back({4'h4, 4'(ihl)});
        hdr.push_back(8'h00);
        hdr.push_back(tot[15:8]);
        hdr.push_back(tot[7:0]);
        hdr.push_back(8'h12); hdr.push_back(8'h34);
        hdr.push_back(8'h40); hdr.push_back(8'h00);
        hdr.push_back(8'h40); hdr.push_back(proto);
        hdr.push_back(8'h00); hdr.push_back(8'h00);
        for (int i = 3; i >= 0; i--) hdr.push_back(SRC_IP[i*8 +: 8]);
        for (int i = 3; i >= 0; i--) hdr.push_back(dip[i*8 +: 8]);
        while (hdr.size() < hlen) hdr.push_back(8'h01);
        s = 32'd0;
        for (int i = 0; i + 1 < hdr.size(); i += 2) s = s + 32'({hdr[i], hdr[i+1]});
        s  = (s & 32'h0000_FFFF) + (s >> 16);
        s  = (s & 32'h0000_FFFF) + (s >> 16);
        cs = ~s[15:0];
        if (bad_csum) cs = cs ^ 16'h0001;
        hdr[10] = cs[15:8];
        hdr[11] = cs[7:0];

        frm.delete();
        repeat (7) frm.push_back(8'h55);
        frm.push_back(8'hD5);
        for (int i = 5; i >= 0; i--) frm.push_back(dmac[i*8 +: 8]);
        for (int i = 5; i >= 0; i--) frm.push_back(SRC_MAC[i*8 +: 8]);
        frm.push_back(etype[15:8]);
        frm.push_back(etype[7:0]);
        foreach (hdr[i]) frm.push_back(hdr[i]);
        frm.push_back(8'h04); frm.push_back(8'hD2);
        frm.push_back(8'h1F); frm.push_back(8'h90);
        frm.push_back(ulen[15:8]); frm.push_back(ulen[7:0]);
        frm.push_back(8'h00); frm.push_back(8'h00);
        foreach (pl[i]) frm.push_back(pl[i]);
        while (frm.size() - 22 < 46) frm.push_back(8'h00);
        frm.push_back(8'h5E); frm.push_back(8'h11);
        frm.push_back(8'h55); frm.push_back(8'hD5);
    endtask

    task automatic send(input int nbytes, input int gap);
        for (int i = 0; i < nbytes; i++) begin
            @(negedge clk);
            gmii_rx_dv = 1'b1;
            gmii_rxd   = frm[i];
        end
        @(negedge clk);
        gmii_rx_dv = 1'b0;
        gmii_rxd   = 8'h00;
        repeat (gap - 1) @(negedge clk);
    endtask

    task automatic flush();
        repeat (12) @(negedge clk);
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        total++;
        if ({rec_en, rec_pkt_done, rx_err} !== 3'b000) begin
            $display("FAIL reset_strobes got=%b want=000", {rec_en, rec_pkt_done, rx_err});
            bad++;
        end
        total++;
        if ({rec_data, rec_byte_num} !== 24'd0) begin
            $display("FAIL reset_data got=%h want=0", {rec_data, rec_byte_num});
            bad++;
        end
        total++;
        if ({src_mac, src_ip} !== 80'd0) begin
            $display("FAIL reset_src got=%h want=0", {src_mac, src_ip});
            bad++;
        end
        rst_n = 1'b1;
        repeat (3) @(negedge clk);
    endtask

    task automatic test_basic();
        pl.delete();
        pl.push_back(8'hDE); pl.push_back(8'hAD); pl.push_back(8'hBE); pl.push_back(8'hEF);
        clr_mon();
        build_frame(BOARD_MAC, 16'h0800, 5, 8'd17, BOARD_IP, 1'b0);
        send(frm.size(), 12);
        flush();
        total++;
        if (got.size() !== 4 || got !== pl) begin
            $display("FAIL basic_payload got_n=%0d want_n=4", got.size());
            bad++;
        end
        total++;
        if (n_done !== 1 || done_num !== 16'd4) begin
            $display("FAIL basic_done got=%0d/%0d want=1/4", n_done, done_num);
            bad++;
        end
        total++;
        if (done_cyc !== last_en_cyc + 1) begin
            $display("FAIL basic_done_timing got=%0d want=%0d", done_cyc, last_en_cyc + 1);
            bad++;
        end
        total++;
        if (src_ip !== SRC_IP || src_mac !== SRC_MAC || n_err !== 0) begin
            $display("FAIL basic_src got=%h/%h/%0d want=%h/%h/0", src_ip, src_mac, n_err, SRC_IP, SRC_MAC);
            bad++;
        end
    endtask

    task automatic test_broadcast();
        pl.delete();
        for (int i = 0; i < 18; i++) pl.push_back(8'(i * 7 + 1));
        clr_mon();
        build_frame(BCAST, 16'h0800, 5, 8'd17, BOARD_IP, 1'b0);
        send(frm.size(), 12);
        flush();
        total++;
        if (got !== pl || n_done !== 1 || done_num !== 16'd18) begin
            $display("FAIL broadcast got_n=%0d done=%0d num=%0d want 18/1/18", got.size(), n_done, done_num);
            bad++;
        end
    endtask

    task automatic test_filter();
        logic [47:0] dm[4];
        logic [15:0] et[4];
        logic [7:0]  pr[4];
        logic [31:0] di[4];
        dm = '{BOARD_MAC, BOARD_MAC, 48'h00_11_22_33_44_66, BOARD_MAC};
        et = '{16'h0800, 16'h0800, 16'h0800, 16'h0806};
        pr = '{8'd17, 8'd6, 8'd17, 8'd17};
        di = '{{8'd192, 8'd168, 8'd1, 8'd99}, BOARD_IP, BOARD_IP, BOARD_IP};
        pl.delete();
        pl.push_back(8'h11); pl.push_back(8'h22);
        for (int k = 0; k < 4; k++) begin
            clr_mon();
            build_frame(dm[k], et[k], 5, pr[k], di[k], 1'b0);
            send(frm.size(), 12);
            flush();
            total++;
            if (got.size() !== 0 || n_done !== 0 || n_err !== 0) begin
                $display("FAIL filter_%0d en=%0d done=%0d err=%0d want 0/0/0", k, got.size(), n_done, n_err);
                bad++;
            end
        end
    endtask

    task automatic test_truncate();
        logic [7:0] exp10[$];
        pl.delete();
        for (int i = 0; i < 100; i++) pl.push_back(8'(i + 8'h30));
        for (int i = 0; i < 10; i++) exp10.push_back(8'(i + 8'h30));
        clr_mon();
        build_frame(BOARD_MAC, 16'h0800, 5, 8'd17, BOARD_IP, 1'b0);
        send(8 + 14 + 20 + 8 + 10, 12);
        flush();
        total++;
        if (got !== exp10 || n_err !== 1 || n_done !== 0) begin
            $display("FAIL truncate en=%0d err=%0d done=%0d want 10/1/0", got.size(), n_err, n_done);
            bad++;
        end
        pl.delete();
        pl.push_back(8'h01); pl.push_back(8'h02); pl.push_back(8'h03);
        clr_mon();
        build_frame(BOARD_MAC, 16'h0800, 5, 8'd17, BOARD_IP, 1'b0);
        send(frm.size(), 12);
        flush();
        total++;
        if (got !== pl || n_done !== 1 || done_num !== 16'd3 || n_err !== 0) begin
            $display("FAIL truncate_recover en=%0d done=%0d num=%0d want 3/1/3", got.size(), n_done, done_num);
            bad++;
        end
    endtask

    task automatic test_options();
        pl.delete();
        pl.push_back(8'h5A); pl.push_back(8'hA5);
        clr_mon();
        build_frame(BOARD_MAC, 16'h0800, 6, 8'd17, BOARD_IP, 1'b0);
        send(frm.size(), 12);
        flush();
        total++;
        if (got !== pl || n_done !== 1 || done_num !== 16'd2) begin
            $display("FAIL options en=%0d done=%0d num=%0d want 2/1/2", got.size(), n_done, done_num);
            bad++;
        end
    endtask

    task automatic test_boundary();
        pl.delete();
        clr_mon();
        build_frame(BOARD_MAC, 16'h0800, 5, 8'd17, BOARD_IP, 1'b0);
        send(frm.size(), 12);
        flush();
        total++;
        if (got.size() !== 0 || n_done !== 1 || done_num !== 16'd0 || n_err !== 0) begin
            $display("FAIL empty_payload en=%0d done=%0d num=%0d want 0/1/0", got.size(), n_done, done_num);
            bad++;
        end
        pl.push_back(8'h77);
        clr_mon();
        build_frame(BOARD_MAC, 16'h0800, 4, 8'd17, BOARD_IP, 1'b0);
        send(frm.size(), 12);
        flush();
        total++;
        if (got.size() !== 0 || n_done !== 0 || n_err !== 1) begin
            $display("FAIL ihl4 en=%0d done=%0d err=%0d want 0/0/1", got.size(), n_done, n_err);
            bad++;
        end
    endtask

    task automatic test_back_to_back();
        logic [7:0] exp[$];
        clr_mon();
        pl.delete();
        for (int i = 0; i < 3; i++) pl.push_back(8'(8'hA0 + i));
        foreach (pl[i]) exp.push_back(pl[i]);
        build_frame(BOARD_MAC, 16'h0800, 5, 8'd17, BOARD_IP, 1'b0);
        send(frm.size(), 1);
        pl.delete();
        for (int i = 0; i < 5; i++) pl.push_back(8'(8'hB0 + i));
        foreach (pl[i]) exp.push_back(pl[i]);
        build_frame(BOARD_MAC, 16'h0800, 5, 8'd17, BOARD_IP, 1'b0);
        send(frm.size(), 12);
        flush();
        total++;
        if (got !== exp || n_done !== 2 || done_num !== 16'd5 || n_err !== 0) begin
            $display("FAIL back_to_back en=%0d done=%0d num=%0d want 8/2/5", got.size(), n_done, done_num);
            bad++;
        end
    endtask

    task automatic test_csum();
        int exp_n;
        int exp_err;
`ifdef UDP_RX_IP_CHECKSUM_EN
        exp_n   = 0;
        exp_err = 1;
`else
        exp_n   = 4;
        exp_err = 0;
`endif
        pl.delete();
        pl.push_back(8'h10); pl.push_back(8'h20); pl.push_back(8'h30); pl.push_back(8'h40);
        clr_mon();
        build_frame(BOARD_MAC, 16'h0800, 5, 8'd17, BOARD_IP, 1'b1);
        send(frm.size(), 12);
        flush();
        total++;
        if (got.size() !== exp_n || n_err !== exp_err || n_done !== (exp_n / 4)) begin
            $display("FAIL bad_csum en=%0d err=%0d done=%0d want %0d/%0d/%0d",
                     got.size(), n_err, n_done, exp_n, exp_err, exp_n / 4);
            bad++;
        end
        clr_mon();
        build_frame(BOARD_MAC, 16'h0800, 6, 8'd17, BOARD_IP, 1'b0);
        send(frm.size(), 12);
        flush();
        total++;
        if (got !== pl || n_done !== 1 || n_err !== 0) begin
            $display("FAIL good_csum en=%0d done=%0d err=%0d want 4/1/0", got.size(), n_done, n_err);
            bad++;
        end
    endtask

    initial begin
        cyc = 0;
        last_en_cyc = 0;
        done_cyc = 0;
        done_num = 16'd0;
        clr_mon();
        test_reset();
        test_basic();
        test_broadcast();
        test_filter();
        test_truncate();
        test_options();
        test_boundary();
        test_back_to_back();
        test_csum();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
